// File: rtl/bitrev_obi_manager_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitrev_obi_manager_pkg : OBI channel types, FSM states, address constants  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bitrev_obi_manager_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        aid;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        mgr_obi_a_chan_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        mgr_obi_r_chan_t r;
    } mgr_obi_rsp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEL     = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        WR_REQ  = 3'd4,
        WR_WAIT = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam logic [31:0] WordBytes = 32'd4;
    localparam logic [3:0]  BeAll     = 4'hF;

    // Byte address of word idx relative to base; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * WordBytes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitrev_obi_manager_obuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stream_obi_obuf : one-entry valid/ready output register with clear        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stream_obi_obuf #(
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          clear_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    input  logic          ready_i
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // A load only happens while empty, so it never collides with a drain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/bitrev_obi_manager.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitrev_obi_manager : OBI manager streaming one frame SRC -> core -> DST    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bitrev_obi_manager
    import bitrev_obi_manager_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned LenW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [31:0]     src_i,
    input  logic [31:0]     dst_i,
    input  logic [LenW-1:0] len_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic            out_valid_o,
    output logic [DW-1:0]   out_data_o,
    input  logic            out_ready_i,
    input  logic            in_valid_i,
    input  logic [DW-1:0]   in_data_i,
    output logic            in_ready_o,
    output mgr_obi_req_t    obi_req_o,
    input  mgr_obi_rsp_t    obi_rsp_i
);

    state_e          state_q, state_d;
    logic [31:0]     src_q, src_d;
    logic [31:0]     dst_q, dst_d;
    logic [LenW-1:0] len_q, len_d;
    logic [LenW-1:0] rd_cnt_q, rd_cnt_d;
    logic [LenW-1:0] wr_cnt_q, wr_cnt_d;
    logic            err_q, err_d;

    logic            obuf_load;
    logic            obuf_clear;

    stream_obi_obuf #(
        .DW (DW)
    ) u_obuf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (obuf_load),
        .data_i  (obi_rsp_i.r.rdata),
        .clear_i (obuf_clear),
        .valid_o (out_valid_o),
        .data_o  (out_data_o),
        .ready_i (out_ready_i)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        obuf_load  = 1'b0;
        obuf_clear = 1'b0;
        obi_req_o  = '0;
        in_ready_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A late rvalid from a transaction cut short by reset lands here and is dropped.
                if (start_i) begin
                    src_d    = src_i & ~32'h3;
                    dst_d    = dst_i & ~32'h3;
                    len_d    = len_i;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    err_d    = 1'b0;
                    state_d  = SEL;
                end
            end
            SEL: begin
                if (wr_cnt_q == len_q) begin
                    state_d = DONE;
                end else if (in_valid_i && (wr_cnt_q < len_q)) begin
                    state_d = WR_REQ;
                end else if ((rd_cnt_q < len_q) && !out_valid_o) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                obi_req_o.req    = 1'b1;
                obi_req_o.a.addr = word_addr(src_q, 32'(rd_cnt_q));
                obi_req_o.a.be   = BeAll;
                if (obi_rsp_i.gnt) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (obi_rsp_i.rvalid) begin
                    if (obi_rsp_i.r.err) begin
                        err_d      = 1'b1;
                        obuf_clear = 1'b1;
                        state_d    = DONE;
                    end else begin
                        obuf_load = 1'b1;
                        rd_cnt_d  = rd_cnt_q + LenW'(1);
                        state_d   = SEL;
                    end
                end
            end
            WR_REQ: begin
                obi_req_o.req     = 1'b1;
                obi_req_o.a.we    = 1'b1;
                obi_req_o.a.addr  = word_addr(dst_q, 32'(wr_cnt_q));
                obi_req_o.a.be    = BeAll;
                obi_req_o.a.wdata = in_data_i;
                // The core word is popped exactly in the grant cycle.
                in_ready_o        = obi_rsp_i.gnt;
                if (obi_rsp_i.gnt) begin
                    wr_cnt_d = wr_cnt_q + LenW'(1);
                    state_d  = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (obi_rsp_i.rvalid) begin
                    if (obi_rsp_i.r.err) begin
                        err_d      = 1'b1;
                        obuf_clear = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = SEL;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign err_o  = err_q;

endmodule
`default_nettype wire
